hazard_fwd_unit: RTL and testbench

- Parametrised next-generation hazard/forwarding control for the in-order pipeline; sits between decode (ID) and execute.
- Compares ID source registers against the destination registers of NUM_STAGES downstream stages and emits registered one-hot forward selects per source, youngest stage first.
- Adds multi-cycle load-use interlock: a counter-driven stall FSM freezes ID until load data is forwardable. Adds pipeline-flush handling.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/fwd_match.sv | 41 ++++
 rtl/hazard_dff.sv | 27 ++
 rtl/hazard_fwd_unit.sv | 166 ++++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the ID-stage hazard/forwarding unit:
//   - HZ_ADDR_W   : default register address width
//   - ST_IDLE/ST_STALL : load-use stall FSM encoding
//   - cnt_width() : width of the stall-length counter for a given load latency
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int HZ_ADDR_W = 5;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  // Counter must hold the longest stall length, LOAD_LAT itself.
  function automatic int cnt_width(input int load_lat);
    return $clog2(load_lat + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// -----------------------------------------------------------------------------
// fwd_match
// One ID source operand compared against every downstream destination.
// Ports:
//   id_valid   in   ID holds a valid instruction
//   src_addr   in   source register address
//   src_en     in   source is actually read
//   stage_rd   in   destination address per stage, stage k at [k*ADDR_W +: ADDR_W]
//   stage_wen  in   stage writes its destination
//   match      out  per-stage raw match vector
//   sel        out  one-hot select of the youngest (lowest index) match
// -----------------------------------------------------------------------------
module fwd_match
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int ADDR_W     = HZ_ADDR_W
) (
  input  logic                         id_valid,
  input  logic [ADDR_W-1:0]            src_addr,
  input  logic                         src_en,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_rd,
  input  logic [NUM_STAGES-1:0]        stage_wen,
  output logic [NUM_STAGES-1:0]        match,
  output logic [NUM_STAGES-1:0]        sel
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    match = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      // x0 is hardwired zero and is never a forwarding source.
      match[k] = id_valid && src_en && (src_addr != '0) && stage_wen[k] &&
                 (stage_rd[k*ADDR_W +: ADDR_W] == src_addr);
    end
    // Isolate the lowest set bit: youngest producer wins.
    sel = match & (~match + NUM_STAGES'(1));
  end

endmodule

// File: rtl/hazard_dff.sv
// -----------------------------------------------------------------------------
// hazard_dff
// Codebase D flip-flop primitive with synchronous active-high reset.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset, loads RST_VAL
//   d    in   next-state value
//   q    out  registered value
// -----------------------------------------------------------------------------
module hazard_dff #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: non-blocking assignment so every flop samples pre-edge values,
  // independent of the order in which always_ff blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
// Hazard detection and operand forwarding control between ID and EX.
// Produces registered one-hot forward selects per source (youngest stage
// first) and a combinational stall that holds ID while a load result is not
// yet forwardable.  A counter-driven FSM extends the stall over several
// cycles when the load is close to ID.
//
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   id_valid       in   ID holds a valid instruction
//   src_addr       in   NUM_SRC*ADDR_W source addresses, s at [s*ADDR_W +: ADDR_W]
//   src_en         in   NUM_SRC source-read enables
//   stage_rd       in   NUM_STAGES*ADDR_W destination per stage (0 = EX)
//   stage_wen      in   NUM_STAGES stage write enables
//   stage_is_load  in   NUM_STAGES stage holds a load with data not yet ready
//   flush          in   pipeline flush, overrides everything
//   stall          out  freeze PC/ID, bubble into EX (combinational)
//   fwd_sel        out  registered one-hot selects, s at [s*NUM_STAGES +: NUM_STAGES]
//   perf_stall_cyc out  (HAZARD_PERF_CNT_EN only) cycles with stall=1
//   perf_fwd_cnt   out  (HAZARD_PERF_CNT_EN only) cycles fwd_sel loaded nonzero
//
// Build option: define HAZARD_PERF_CNT_EN to add the two performance counters.
// -----------------------------------------------------------------------------
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3,
  parameter int ADDR_W     = HZ_ADDR_W,
  parameter int LOAD_LAT   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]     src_addr,
  input  logic [NUM_SRC-1:0]            src_en,
  input  logic [NUM_STAGES*ADDR_W-1:0]  stage_rd,
  input  logic [NUM_STAGES-1:0]         stage_wen,
  input  logic [NUM_STAGES-1:0]         stage_is_load,
  input  logic                          flush,
  output logic                          stall,
  output logic [NUM_SRC*NUM_STAGES-1:0] fwd_sel
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_stall_cyc,
  output logic [31:0]                   perf_fwd_cnt
`endif
);

  localparam int CNT_W = cnt_width(LOAD_LAT);

  logic [NUM_STAGES-1:0]         match_v [NUM_SRC];
  logic [NUM_SRC*NUM_STAGES-1:0] sel_all;
  logic [NUM_STAGES-1:0]         any_match;
  logic [NUM_STAGES-1:0]         haz;
  logic [CNT_W-1:0]              req_len;

  logic [0:0]                    state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [NUM_SRC*NUM_STAGES-1:0] fwd_d;

  // ---------------------------------------------------------------------------
  // Per-source comparison and priority selection
  // ---------------------------------------------------------------------------
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_match #(
      .NUM_STAGES (NUM_STAGES),
      .ADDR_W     (ADDR_W)
    ) u_match (
      .id_valid  (id_valid),
      .src_addr  (src_addr[s*ADDR_W +: ADDR_W]),
      .src_en    (src_en[s]),
      .stage_rd  (stage_rd),
      .stage_wen (stage_wen),
      .match     (match_v[s]),
      .sel       (sel_all[s*NUM_STAGES +: NUM_STAGES])
    );
  end

  // ---------------------------------------------------------------------------
  // Load-use hazard: only loads closer than LOAD_LAT need ID held back.
  // The youngest hazardous load sets the longest required stall.
  // ---------------------------------------------------------------------------
  always_comb begin
    any_match = '0;
    for (int s = 0; s < NUM_SRC; s++) any_match |= match_v[s];
    haz     = '0;
    req_len = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      haz[k] = (k < LOAD_LAT) && stage_is_load[k] && any_match[k];
    end
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (haz[k]) req_len = CNT_W'(LOAD_LAT - k);
    end
  end

  // ---------------------------------------------------------------------------
  // Stall FSM: IDLE raises the first stall cycle itself; STALL covers the rest.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          stall = |haz;
          if (req_len > CNT_W'(1)) begin
            state_d = ST_STALL;
            cnt_d   = req_len - CNT_W'(1);
          end
        end
        default: begin
          stall = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

  // A stalled or flushed instruction never reaches EX, so it must not forward.
  assign fwd_d = (flush || stall || !id_valid) ? '0 : sel_all;

  hazard_dff #(.W(1), .RST_VAL(ST_IDLE)) u_state_dff (
    .clk (clk), .rst (rst), .d (state_d), .q (state_q)
  );

  hazard_dff #(.W(CNT_W)) u_cnt_dff (
    .clk (clk), .rst (rst), .d (cnt_d), .q (cnt_q)
  );

  hazard_dff #(.W(NUM_SRC*NUM_STAGES)) u_fwd_dff (
    .clk (clk), .rst (rst), .d (fwd_d), .q (fwd_sel)
  );

  // ---------------------------------------------------------------------------
  // Optional performance counters (free-running, wrap at 2^32, flush-immune)
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_d, perf_fwd_d;

  assign perf_stall_d = perf_stall_cyc + {31'd0, stall};
  assign perf_fwd_d   = perf_fwd_cnt + {31'd0, |fwd_d};

  hazard_dff #(.W(32)) u_perf_stall_dff (
    .clk (clk), .rst (rst), .d (perf_stall_d), .q (perf_stall_cyc)
  );

  hazard_dff #(.W(32)) u_perf_fwd_dff (
    .clk (clk), .rst (rst), .d (perf_fwd_d), .q (perf_fwd_cnt)
  );
`else
  // Counters not built; no extra state.
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_unit
// Directed, table-driven bench for hazard_fwd_unit at default parameters
// (NUM_SRC=2, NUM_STAGES=3, ADDR_W=5, LOAD_LAT=2), followed by hand-written
// multi-cycle sequences for the stall FSM, flush and reset corner cases.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_unit;

  localparam int NUM_SRC    = 2;
  localparam int NUM_STAGES = 3;
  localparam int ADDR_W     = 5;
  localparam int LOAD_LAT   = 2;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          id_valid;
  logic [NUM_SRC*ADDR_W-1:0]     src_addr;
  logic [NUM_SRC-1:0]            src_en;
  logic [NUM_STAGES*ADDR_W-1:0]  stage_rd;
  logic [NUM_STAGES-1:0]         stage_wen;
  logic [NUM_STAGES-1:0]         stage_is_load;
  logic                          flush;
  logic                          stall;
  logic [NUM_SRC*NUM_STAGES-1:0] fwd_sel;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]                   perf_stall_cyc;
  logic [31:0]                   perf_fwd_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(
    .NUM_SRC    (NUM_SRC),
    .NUM_STAGES (NUM_STAGES),
    .ADDR_W     (ADDR_W),
    .LOAD_LAT   (LOAD_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .src_addr      (src_addr),
    .src_en        (src_en),
    .stage_rd      (stage_rd),
    .stage_wen     (stage_wen),
    .stage_is_load (stage_is_load),
    .flush         (flush),
    .stall         (stall),
    .fwd_sel       (fwd_sel)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_fwd_cnt   (perf_fwd_cnt)
`endif
  );

  typedef struct {
    string      name;
    logic       v;
    logic [4:0] s1, s0;
    logic [1:0] en;
    logic [4:0] r2, r1, r0;
    logic [2:0] wen, ld;
    logic       fl;
    logic       exp_stall;
    logic [5:0] exp_fwd;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s0,
                       input logic [1:0] en, input logic [4:0] r2, input logic [4:0] r1,
                       input logic [4:0] r0, input logic [2:0] wen, input logic [2:0] ld,
                       input logic fl);
    id_valid      = v;
    src_addr      = {s1, s0};
    src_en        = en;
    stage_rd      = {r2, r1, r0};
    stage_wen     = wen;
    stage_is_load = ld;
    flush         = fl;
  endtask

  task automatic drive_idle();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 1'b0);
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(string name, logic v, logic [4:0] s1, logic [4:0] s0,
                              logic [1:0] en, logic [4:0] r2, logic [4:0] r1, logic [4:0] r0,
                              logic [2:0] wen, logic [2:0] ld, logic fl,
                              logic es, logic [5:0] ef);
    vec_t t;
    t.name = name; t.v = v; t.s1 = s1; t.s0 = s0; t.en = en;
    t.r2 = r2; t.r1 = r1; t.r0 = r0; t.wen = wen; t.ld = ld; t.fl = fl;
    t.exp_stall = es; t.exp_fwd = ef;
    return t;
  endfunction

  // Load in EX matching src0 (x3): the canonical 2-cycle load-use case,
  // with the pipeline advancing underneath the frozen ID instruction.
  task automatic run_load_use(input string tag);
    drive(1'b1, 5'd0, 5'd3, 2'b01, 5'd0, 5'd0, 5'd3, 3'b001, 3'b001, 1'b0);
    #1 check({tag, "_c1_stall"}, {31'd0, stall}, 32'd1);
    tick();
    check({tag, "_c1_fwd"}, {26'd0, fwd_sel}, 32'd0);
    drive(1'b1, 5'd0, 5'd3, 2'b01, 5'd0, 5'd3, 5'd0, 3'b010, 3'b010, 1'b0);
    #1 check({tag, "_c2_stall"}, {31'd0, stall}, 32'd1);
    tick();
    check({tag, "_c2_fwd"}, {26'd0, fwd_sel}, 32'd0);
    drive(1'b1, 5'd0, 5'd3, 2'b01, 5'd3, 5'd0, 5'd0, 3'b100, 3'b100, 1'b0);
    #1 check({tag, "_c3_stall"}, {31'd0, stall}, 32'd0);
    tick();
    check({tag, "_c3_fwd"}, {26'd0, fwd_sel}, 32'h04);
    drive_idle();
    tick();
  endtask

  initial begin
    //            name                 v   s1  s0  en     r2  r1  r0  wen     ld      fl  stall fwd
    vecs[0]  = mk("fwd_s0_ex",         1,  0,  5,  2'b01, 0,  0,  5,  3'b001, 3'b000, 0,  0, 6'b000_001);
    vecs[1]  = mk("youngest_wins",     1,  7,  0,  2'b10, 7,  0,  7,  3'b101, 3'b000, 0,  0, 6'b001_000);
    vecs[2]  = mk("src_x0_no_fwd",     1,  0,  0,  2'b10, 0,  0,  0,  3'b101, 3'b000, 0,  0, 6'b000_000);
    vecs[3]  = mk("id_invalid",        0,  0,  5,  2'b01, 0,  0,  5,  3'b001, 3'b000, 0,  0, 6'b000_000);
    vecs[4]  = mk("src_disabled",      1,  5,  5,  2'b00, 0,  5,  5,  3'b011, 3'b000, 0,  0, 6'b000_000);
    vecs[5]  = mk("wen0_load_ignored", 1,  0,  6,  2'b01, 0,  6,  6,  3'b000, 3'b011, 0,  0, 6'b000_000);
    vecs[6]  = mk("two_sources",       1,  9,  3,  2'b11, 9,  3,  0,  3'b110, 3'b000, 0,  0, 6'b100_010);
    vecs[7]  = mk("load_s2_fwd",       1,  0,  8,  2'b01, 8,  0,  0,  3'b100, 3'b100, 0,  0, 6'b000_100);
    vecs[8]  = mk("load_s1_stall",     1,  4,  0,  2'b10, 0,  4,  0,  3'b010, 3'b010, 0,  1, 6'b000_000);
    vecs[9]  = mk("after_1cyc_stall",  1,  4,  0,  2'b10, 4,  0,  0,  3'b100, 3'b100, 0,  0, 6'b100_000);
    vecs[10] = mk("flush_fwd",         1,  0,  5,  2'b01, 0,  0,  5,  3'b001, 3'b000, 1,  0, 6'b000_000);
    vecs[11] = mk("flush_over_haz",    1,  0,  3,  2'b01, 0,  0,  3,  3'b001, 3'b001, 1,  0, 6'b000_000);
    vecs[12] = mk("mid_priority",      1,  0,  2,  2'b01, 2,  2,  0,  3'b110, 3'b000, 0,  0, 6'b000_010);
    vecs[13] = mk("same_stage_both",   1,  6,  6,  2'b11, 0,  0,  6,  3'b001, 3'b000, 0,  0, 6'b001_001);

    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_fwd", {26'd0, fwd_sel}, 32'd0);

    // Single-cycle vectors; none of them leaves the FSM outside IDLE.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].v, vecs[i].s1, vecs[i].s0, vecs[i].en, vecs[i].r2, vecs[i].r1,
            vecs[i].r0, vecs[i].wen, vecs[i].ld, vecs[i].fl);
      #1 check({vecs[i].name, "_stall"}, {31'd0, stall}, {31'd0, vecs[i].exp_stall});
      tick();
      check({vecs[i].name, "_fwd"}, {26'd0, fwd_sel}, {26'd0, vecs[i].exp_fwd});
    end
    drive_idle();
    tick();

    run_load_use("load_use");

    // Two loads (EX and MEM) hit by different sources: the longer stall wins,
    // and the second cycle comes from the counter even with ID now empty.
    drive(1'b1, 5'd4, 5'd3, 2'b11, 5'd0, 5'd3, 5'd4, 3'b011, 3'b011, 1'b0);
    #1 check("multi_load_c1_stall", {31'd0, stall}, 32'd1);
    tick();
    drive_idle();
    #1 check("multi_load_c2_stall", {31'd0, stall}, 32'd1);
    tick();
    check("multi_load_c3_stall", {31'd0, stall}, 32'd0);

    // Flush in the first STALL cycle.
    drive(1'b1, 5'd0, 5'd3, 2'b01, 5'd0, 5'd0, 5'd3, 3'b001, 3'b001, 1'b0);
    #1 check("flush_seq_c1_stall", {31'd0, stall}, 32'd1);
    tick();
    drive(1'b1, 5'd0, 5'd3, 2'b01, 5'd0, 5'd3, 5'd0, 3'b010, 3'b010, 1'b1);
    #1 check("flush_seq_c2_stall", {31'd0, stall}, 32'd0);
    tick();
    check("flush_seq_c2_fwd", {26'd0, fwd_sel}, 32'd0);
    drive(1'b1, 5'd0, 5'd3, 2'b01, 5'd3, 5'd0, 5'd0, 3'b100, 3'b100, 1'b0);
    #1 check("flush_seq_c3_stall", {31'd0, stall}, 32'd0);
    tick();
    check("flush_seq_c3_fwd", {26'd0, fwd_sel}, 32'h04);
    drive_idle();
    tick();

    // Reset on the cycle that would enter STALL: no residual stall.
    drive(1'b1, 5'd0, 5'd3, 2'b01, 5'd0, 5'd0, 5'd3, 3'b001, 3'b001, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_idle();
    #1 check("rst_entry_stall", {31'd0, stall}, 32'd0);
    check("rst_entry_fwd", {26'd0, fwd_sel}, 32'd0);
    tick();

    // Reset while in STALL.
    drive(1'b1, 5'd0, 5'd3, 2'b01, 5'd0, 5'd0, 5'd3, 3'b001, 3'b001, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_idle();
    #1 check("rst_mid_stall", {31'd0, stall}, 32'd0);
    check("rst_mid_fwd", {26'd0, fwd_sel}, 32'd0);

    // Reset overrides a pending forward.
    drive(1'b1, 5'd0, 5'd5, 2'b01, 5'd0, 5'd0, 5'd5, 3'b001, 3'b000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_idle();
    check("rst_clears_fwd", {26'd0, fwd_sel}, 32'd0);
    tick();

`ifdef HAZARD_PERF_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("perf_reset_stall", perf_stall_cyc, 32'd0);
    check("perf_reset_fwd", perf_fwd_cnt, 32'd0);
    run_load_use("perf_lu");
    check("perf_stall_cyc", perf_stall_cyc, 32'd2);
    check("perf_fwd_cnt", perf_fwd_cnt, 32'd1);

    dut.u_perf_stall_dff.q = 32'hFFFF_FFFF;
    dut.u_perf_fwd_dff.q   = 32'hFFFF_FFFF;
    drive(1'b1, 5'd0, 5'd5, 2'b01, 5'd0, 5'd0, 5'd5, 3'b001, 3'b000, 1'b0);
    tick();
    check("perf_fwd_wrap", perf_fwd_cnt, 32'd0);
    check("perf_stall_hold", perf_stall_cyc, 32'hFFFF_FFFF);
    drive(1'b1, 5'd4, 5'd0, 2'b10, 5'd0, 5'd4, 5'd0, 3'b010, 3'b010, 1'b0);
    tick();
    drive_idle();
    check("perf_stall_wrap", perf_stall_cyc, 32'd0);
    check("perf_fwd_after_wrap", perf_fwd_cnt, 32'd0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
